// File: rtl/memory_arbiter_pkg.sv
// Shared types and helpers for the memory arbiter and its round-robin picker.
// Optional build macro: MEMORY_ARBITER_STATS_EN (per-requester grant counters).
package memory_arbiter_pkg;

    localparam int STAT_WIDTH = 32;
    localparam int MAX_REQ    = 8;

    // One-hot pick of the first valid requester at or after ptr, wrapping mod n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] g;
        logic [2:0]         idx;
        logic               found;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n && !found) begin
                idx = 3'((int'(ptr) + k) % n);
                if (valid[idx]) begin
                    g[idx] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/memory_arbiter_memory.sv
// Single-port synchronous RAM, write-first: a write echoes its data on the read port.
// Contents are never cleared by reset.
module Memory #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // One access per cycle; read data registered, writes pass through.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
            o_rdata       <= i_wdata;
        end else begin
            o_rdata <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/memory_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick plus rotating priority pointer.
// Reusable for any shared resource with up to eight requesters.
module rr_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_valid,
    output logic [N-1:0] o_grant
);

    logic [2:0]         r_ptr;
    logic [MAX_REQ-1:0] w_pick;
    logic [2:0]         w_idx;
    logic [2:0]         w_next;
    logic               w_unused;

    assign w_pick   = rr_pick(MAX_REQ'(i_valid), r_ptr, N);
    assign w_unused = ^w_pick;
    // No grant is ever issued while reset is held.
    assign o_grant  = i_rst ? '0 : w_pick[N-1:0];

    // Encode the granted index and the pointer value that follows it.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < N; i++) begin
            if (o_grant[i]) w_idx = 3'(i);
        end
        w_next = 3'((int'(w_idx) + 1) % N);
    end

    // Advance priority past the winner; hold when nothing was granted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 3'd0;
        end else if (|o_grant) begin
            r_ptr <= w_next;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin sharing of one single-port RAM among NUM_REQ requesters.
// Optional build macro: MEMORY_ARBITER_STATS_EN adds the grantCount port.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 1024,
    parameter int WIDTH   = 32,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       reqValid,
    output logic [NUM_REQ-1:0]       reqReady,
    input  logic [NUM_REQ-1:0]       reqWrite,
    input  logic [NUM_REQ*AW-1:0]    reqAddress,
    input  logic [NUM_REQ*WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]       respValid,
    output logic [WIDTH-1:0]         respData
`ifdef MEMORY_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*STAT_WIDTH-1:0] grantCount
`endif
);

    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] r_respTag;
    logic               w_we;
    logic [AW-1:0]      w_addr;
    logic [WIDTH-1:0]   w_wdata;
    logic [WIDTH-1:0]   w_rdata;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_valid (reqValid),
        .o_grant (w_grant)
    );

    assign reqReady = w_grant;

    // Steer the granted command onto the RAM; idle cycles do a harmless read of 0.
    always_comb begin
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_we    = reqWrite[i];
                w_addr  = reqAddress[i*AW +: AW];
                w_wdata = reqData[i*WIDTH +: WIDTH];
            end
        end
    end

    Memory #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (clock),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    // Remember who was granted so the RAM output is routed back next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_respTag <= '0;
        end else begin
            r_respTag <= w_grant;
        end
    end

    // A reset arriving the cycle after a grant kills that response at once.
    assign respValid = reset ? '0 : r_respTag;
    assign respData  = w_rdata;

`ifdef MEMORY_ARBITER_STATS_EN
    logic [STAT_WIDTH-1:0] r_grantCount [NUM_REQ];

    // Per-requester accepted-command counters, saturating at all-ones.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset) begin
                r_grantCount[i] <= '0;
            end else if (w_grant[i] && reqValid[i] && r_grantCount[i] != '1) begin
                r_grantCount[i] <= r_grantCount[i] + 1'b1;
            end
        end
    end

    // Flatten the counter array onto the packed port.
    always_comb begin
        grantCount = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grantCount[i*STAT_WIDTH +: STAT_WIDTH] = r_grantCount[i];
        end
    end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter with a queue-free behavioural model.
// Optional build macro: MEMORY_ARBITER_STATS_EN enables the counter checks.
module tb_memory_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int W  = 32;

    logic           clock;
    logic           reset;
    logic [N-1:0]   reqValid;
    logic [N-1:0]   reqReady;
    logic [N-1:0]   reqWrite;
    logic [N*AW-1:0] reqAddress;
    logic [N*W-1:0] reqData;
    logic [N-1:0]   respValid;
    logic [W-1:0]   respData;
`ifdef MEMORY_ARBITER_STATS_EN
    logic [N*32-1:0] grantCount;
`endif

    memory_arbiter #(
        .NUM_REQ (N),
        .DEPTH   (1024),
        .WIDTH   (W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .reqValid   (reqValid),
        .reqReady   (reqReady),
        .reqWrite   (reqWrite),
        .reqAddress (reqAddress),
        .reqData    (reqData),
        .respValid  (respValid),
        .respData   (respData)
`ifdef MEMORY_ARBITER_STATS_EN
        ,
        .grantCount (grantCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int          m_ptr = 0;
    logic [N-1:0] m_tag = '0;
    logic [W-1:0] m_data = '0;
    bit          m_known = 0;
    logic [W-1:0] m_mem [1024];
    bit          m_wr [1024];
    int          m_cnt [N];

    function automatic logic [N-1:0] model_grant();
        int idx;
        if (reset) return '0;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (reqValid[idx]) return N'(1) << idx;
        end
        return '0;
    endfunction

    function automatic void expect_now(
        output logic [N-1:0] eg,
        output logic [N-1:0] erv,
        output logic [W-1:0] ed,
        output bit           ek
    );
        eg  = model_grant();
        erv = reset ? '0 : m_tag;
        ed  = m_data;
        ek  = m_known && (erv != '0);
    endfunction

    task automatic tick();
        logic [N-1:0] eg;
        int           g;
        int           a;
        eg = model_grant();
        g  = -1;
        for (int i = 0; i < N; i++) if (eg[i]) g = i;
        if (reset) begin
            m_ptr = 0;
            m_tag = '0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (g >= 0) begin
            a = int'(reqAddress[g*AW +: AW]);
            if (reqWrite[g]) begin
                m_mem[a] = reqData[g*W +: W];
                m_wr[a]  = 1;
                m_data   = reqData[g*W +: W];
                m_known  = 1;
            end else begin
                m_data  = m_mem[a];
                m_known = m_wr[a];
            end
            m_tag = eg;
            m_ptr = (g + 1) % N;
            m_cnt[g]++;
        end else begin
            m_tag = '0;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_cmd(input int i, input logic wr, input logic [AW-1:0] a,
                           input logic [W-1:0] d);
        reqWrite[i]           = wr;
        reqAddress[i*AW +: AW] = a;
        reqData[i*W +: W]     = d;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        reqValid = '1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (reqReady !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_ready: got %b want 0000", reqReady);
            end
            n_checks++;
            if (respValid !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_resp: got %b want 0000", respValid);
            end
            tick();
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (reqReady !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b want 0001", reqReady);
        end
        reqValid = '0;
        tick();
    endtask

    task automatic test_round_robin();
        int           seen [N];
        logic [N-1:0] eg, erv;
        logic [W-1:0] ed;
        bit           ek;
        for (int i = 0; i < N; i++) seen[i] = 0;
        reqValid = '1;
        reqWrite = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            expect_now(eg, erv, ed, ek);
            n_checks++;
            if (reqReady !== eg) begin
                n_fail++;
                $display("FAIL rr_grant c=%0d: got %b want %b", c, reqReady, eg);
            end
            n_checks++;
            if (reqReady !== (N'(1) << (c % N))) begin
                n_fail++;
                $display("FAIL rr_order c=%0d: got %b want %b", c, reqReady,
                         N'(1) << (c % N));
            end
            for (int i = 0; i < N; i++) if (reqReady[i]) seen[i]++;
            tick();
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (seen[i] != 2) begin
                n_fail++;
                $display("FAIL rr_share req%0d: got %0d want 2", i, seen[i]);
            end
        end
        reqValid = '0;
        tick();
    endtask

    task automatic test_raw();
        reqValid = 4'b0100;
        set_cmd(2, 1'b1, 10'h010, 32'hDEADBEEF);
        #1;
        n_checks++;
        if (reqReady !== 4'b0100) begin
            n_fail++;
            $display("FAIL raw_wgrant: got %b want 0100", reqReady);
        end
        tick();
        reqValid = 4'b0001;
        set_cmd(0, 1'b0, 10'h010, 32'h0);
        reqWrite[2] = 1'b0;
        #1;
        n_checks++;
        if (reqReady !== 4'b0001 || respValid !== 4'b0100 || respData !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL raw_wresp: ready %b resp %b data %h want 0001 0100 deadbeef",
                     reqReady, respValid, respData);
        end
        tick();
        reqValid = '0;
        #1;
        n_checks++;
        if (respValid !== 4'b0001 || respData !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL raw_read: resp %b data %h want 0001 deadbeef", respValid, respData);
        end
        tick();
    endtask

    task automatic test_single();
        reqValid = 4'b1000;
        set_cmd(3, 1'b0, 10'h001, 32'h0);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (reqReady !== 4'b1000) begin
                n_fail++;
                $display("FAIL single_grant c=%0d: got %b want 1000", c, reqReady);
            end
            tick();
        end
        reqValid = 4'b1010;
        set_cmd(1, 1'b0, 10'h002, 32'h0);
        #1;
        n_checks++;
        if (reqReady !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_join: got %b want 0010", reqReady);
        end
        tick();
        reqValid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        reqValid = 4'b0001;
        set_cmd(0, 1'b0, 10'h010, 32'h0);
        #1;
        n_checks++;
        if (reqReady !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_grant: got %b want 0001", reqReady);
        end
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (respValid !== 4'b0000 || reqReady !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_suppress: resp %b ready %b want 0000 0000",
                     respValid, reqReady);
        end
        tick();
        reset    = 1'b0;
        reqValid = 4'b0010;
        set_cmd(1, 1'b0, 10'h010, 32'h0);
        #1;
        n_checks++;
        if (reqReady !== 4'b0010 || respValid !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_after: ready %b resp %b want 0010 0000",
                     reqReady, respValid);
        end
        tick();
        reqValid = '0;
        #1;
        n_checks++;
        if (respValid !== 4'b0010 || respData !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL midrst_resp: resp %b data %h want 0010 deadbeef",
                     respValid, respData);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] eg, erv;
        logic [W-1:0] ed;
        bit           ek;
        for (int c = 0; c < 300; c++) begin
            reset    = ($urandom_range(0, 39) == 0);
            reqValid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                set_cmd(i, 1'($urandom), AW'($urandom_range(0, 15)), $urandom);
            end
            #1;
            expect_now(eg, erv, ed, ek);
            n_checks++;
            if (reqReady !== eg) begin
                n_fail++;
                $display("FAIL rand_ready c=%0d: got %b want %b", c, reqReady, eg);
            end
            n_checks++;
            if (respValid !== erv) begin
                n_fail++;
                $display("FAIL rand_resp c=%0d: got %b want %b", c, respValid, erv);
            end
            if (ek) begin
                n_checks++;
                if (respData !== ed) begin
                    n_fail++;
                    $display("FAIL rand_data c=%0d: got %h want %h", c, respData, ed);
                end
            end
            tick();
        end
        reset    = 1'b0;
        reqValid = '0;
        tick();
    endtask

`ifdef MEMORY_ARBITER_STATS_EN
    task automatic test_stats();
        reset    = 1'b1;
        reqValid = '0;
        tick();
        reset = 1'b0;
        reqValid = 4'b0010;
        for (int c = 0; c < 10; c++) tick();
        for (int c = 0; c < 12; c++) begin
            reqValid = N'($urandom) & 4'b1101;
            tick();
        end
        reqValid = '0;
        #1;
        n_checks++;
        if (grantCount[32 +: 32] !== 32'd10) begin
            n_fail++;
            $display("FAIL stats_req1: got %0d want 10", grantCount[32 +: 32]);
        end
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (grantCount[i*32 +: 32] !== 32'(m_cnt[i])) begin
                n_fail++;
                $display("FAIL stats_req%0d: got %0d want %0d", i,
                         grantCount[i*32 +: 32], m_cnt[i]);
            end
        end
        tick();
    endtask
`endif

    initial begin
        reset      = 1'b1;
        reqValid   = '0;
        reqWrite   = '0;
        reqAddress = '0;
        reqData    = '0;
        for (int i = 0; i < 1024; i++) begin
            m_mem[i] = '0;
            m_wr[i]  = 0;
        end
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        @(negedge clock);
        test_reset();
        test_round_robin();
        test_raw();
        test_single();
        test_reset_mid();
        test_random();
`ifdef MEMORY_ARBITER_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
